// File: rtl/except_unit_pkg.sv
// except_unit_pkg: cause codes, FSM states and default constants for the exception initiator
package except_unit_pkg;
  typedef enum logic [2:0] {
    EXC_NONE    = 3'd0,
    EXC_INTR    = 3'd1,
    EXC_ADDRERR = 3'd2,
    EXC_OVF     = 3'd3,
    EXC_SYSCALL = 3'd4,
    EXC_BREAK   = 3'd5,
    EXC_DECERR  = 3'd6
  } exc_code_e;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    DRAIN = 2'd2
  } state_e;
  localparam int VEC_STRIDE_DFLT = 5;
  localparam int DRAIN_DFLT      = 3;
endpackage

// File: rtl/except_unit_if.sv
// except_unit_if: exception-entry and fetch-redirect signals from the initiator to COP0/pipeline
interface except_unit_if;
  logic        except_start;
  logic        except_dly_slt;
  logic [31:0] except_raddr;
  logic [31:0] except_raddr_dly;
  logic        nullify_decode;
  logic        nullify_execute;
  logic        nullify_mem;
  logic        nullify_wb;
  logic        redirect;
  logic [31:0] redirect_addr;
  modport master (
    output except_start, except_dly_slt, except_raddr, except_raddr_dly,
           nullify_decode, nullify_execute, nullify_mem, nullify_wb, redirect, redirect_addr
  );
  modport slave (
    input except_start, except_dly_slt, except_raddr, except_raddr_dly,
          nullify_decode, nullify_execute, nullify_mem, nullify_wb, redirect, redirect_addr
  );
endinterface

// File: rtl/except_prio_enc.sv
// except_prio_enc: picks the oldest pending exception and its stage PC / delay-slot flag
module except_prio_enc
  import except_unit_pkg::*;
(
  input  logic        i_intr_pend,
  input  logic        i_decode_error_p1,
  input  logic        i_syscall_p1,
  input  logic        i_break_p1,
  input  logic        i_overflow_p2,
  input  logic        i_addr_error_p3,
  input  logic        i_valid_p1,
  input  logic        i_valid_p2,
  input  logic        i_valid_p3,
  input  logic [31:0] i_pc_p1,
  input  logic [31:0] i_pc_p2,
  input  logic [31:0] i_pc_p3,
  input  logic        i_dly_slt_p1,
  input  logic        i_dly_slt_p2,
  input  logic        i_dly_slt_p3,
  output logic        o_valid,
  output exc_code_e   o_code,
  output logic [31:0] o_pc,
  output logic        o_dly_slt
);
  logic w_p3, w_p2;
  assign w_p3 = i_valid_p3 && i_addr_error_p3;
  assign w_p2 = (i_valid_p2 && i_overflow_p2) || i_intr_pend;
  always_comb begin
    o_code    = w_p3                              ? EXC_ADDRERR :
                (i_valid_p2 && i_overflow_p2)     ? EXC_OVF     :
                i_intr_pend                       ? EXC_INTR    :
                !i_valid_p1                       ? EXC_NONE    :
                i_decode_error_p1                 ? EXC_DECERR  :
                i_syscall_p1                      ? EXC_SYSCALL :
                i_break_p1                        ? EXC_BREAK   : EXC_NONE;
    o_valid   = o_code != EXC_NONE;
    o_pc      = w_p3 ? i_pc_p3 : w_p2 ? i_pc_p2 : i_pc_p1;
    o_dly_slt = w_p3 ? i_dly_slt_p3 : w_p2 ? i_dly_slt_p2 : i_dly_slt_p1;
  end
endmodule

// File: rtl/except_unit.sv
// except_unit: exception/interrupt initiator driving COP0 entry, stage nullifies and fetch redirect
module except_unit
  import except_unit_pkg::*;
#(
  parameter int VEC_STRIDE_LOG2 = VEC_STRIDE_DFLT,
  parameter int DRAIN_CYCLES    = DRAIN_DFLT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_exec_stall,
  input  logic                i_mem_stall,
  input  logic                i_fetch_stall,
  input  logic [21:0]         i_cop0_ivtbase,
  input  logic                i_cop0_ie,
  input  logic                i_intr,
  input  logic                i_decode_error_p1,
  input  logic                i_syscall_p1,
  input  logic                i_break_p1,
  input  logic                i_overflow_p2,
  input  logic                i_addr_error_p3,
  input  logic                i_valid_p1,
  input  logic                i_valid_p2,
  input  logic                i_valid_p3,
  input  logic [31:0]         i_pc_p1,
  input  logic [31:0]         i_pc_p2,
  input  logic [31:0]         i_pc_p3,
  input  logic                i_dly_slt_p1,
  input  logic                i_dly_slt_p2,
  input  logic                i_dly_slt_p3,
  except_unit_if.master       o_exc
);
  localparam int CW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  logic          w_adv, w_intr_pend, w_sel_valid, w_sel_dly, w_entry;
  exc_code_e     w_sel_code;
  logic [31:0]   w_sel_pc;
  state_e        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  exc_code_e     r_code;
  logic [31:0]   r_pc;
  logic          r_dly, r_intr_q;
  assign w_adv       = !(i_exec_stall || i_mem_stall || i_fetch_stall);
  assign w_intr_pend = r_intr_q && i_cop0_ie && i_valid_p2;
  except_prio_enc u_enc (
    .i_intr_pend      (w_intr_pend),
    .i_decode_error_p1(i_decode_error_p1),
    .i_syscall_p1     (i_syscall_p1),
    .i_break_p1       (i_break_p1),
    .i_overflow_p2    (i_overflow_p2),
    .i_addr_error_p3  (i_addr_error_p3),
    .i_valid_p1       (i_valid_p1),
    .i_valid_p2       (i_valid_p2),
    .i_valid_p3       (i_valid_p3),
    .i_pc_p1          (i_pc_p1),
    .i_pc_p2          (i_pc_p2),
    .i_pc_p3          (i_pc_p3),
    .i_dly_slt_p1     (i_dly_slt_p1),
    .i_dly_slt_p2     (i_dly_slt_p2),
    .i_dly_slt_p3     (i_dly_slt_p3),
    .o_valid          (w_sel_valid),
    .o_code           (w_sel_code),
    .o_pc             (w_sel_pc),
    .o_dly_slt        (w_sel_dly)
  );
  always_comb begin
    w_state_nxt = r_state;
    if (w_adv)
      w_state_nxt = r_state == IDLE  ? (w_sel_valid ? ENTRY : IDLE) :
                    r_state == ENTRY ? DRAIN :
                    (r_cnt == '0 ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_intr_q <= 1'b0;
      r_code   <= EXC_NONE;
      r_pc     <= '0;
      r_dly    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_adv) begin
        r_intr_q <= i_intr;
        if (r_state == IDLE && w_sel_valid) begin
          r_code <= w_sel_code;
          r_pc   <= w_sel_pc;
          r_dly  <= w_sel_dly;
        end
        if (r_state == ENTRY) r_cnt <= CW'(DRAIN_CYCLES - 1);
        else if (r_state == DRAIN && r_cnt != '0) r_cnt <= r_cnt - CW'(1);
      end
    end
  end
  // start and nullify_wb share one source: COP0 only honours start alongside a WB squash
  assign w_entry                = r_state == ENTRY;
  assign o_exc.except_start     = w_entry;
  assign o_exc.nullify_wb       = w_entry;
  assign o_exc.nullify_mem      = w_entry;
  assign o_exc.nullify_execute  = w_entry;
  assign o_exc.nullify_decode   = w_entry;
  assign o_exc.redirect         = w_entry;
  assign o_exc.except_dly_slt   = w_entry && r_dly;
  assign o_exc.except_raddr     = w_entry ? r_pc : '0;
  assign o_exc.except_raddr_dly = w_entry ? r_pc - 32'd4 : '0;
  assign o_exc.redirect_addr    = w_entry ? ({i_cop0_ivtbase, 10'b0} | (32'(r_code) << VEC_STRIDE_LOG2)) : '0;
endmodule

// File: tb/tb_except_unit.sv
// tb_except_unit: directed vectors with hand-computed expectations for except_unit
module tb_except_unit;
  logic        clk = 0, rst = 1;
  logic        exec_stall, mem_stall, fetch_stall, ie, intr;
  logic [21:0] ivtbase;
  logic        decerr_p1, syscall_p1, break_p1, ovf_p2, addrerr_p3;
  logic        valid_p1, valid_p2, valid_p3, dly_p1, dly_p2, dly_p3;
  logic [31:0] pc_p1, pc_p2, pc_p3;
  int          n_vec = 0, n_err = 0;
  except_unit_if u_if ();
  except_unit dut (
    .clk(clk), .rst(rst),
    .i_exec_stall(exec_stall), .i_mem_stall(mem_stall), .i_fetch_stall(fetch_stall),
    .i_cop0_ivtbase(ivtbase), .i_cop0_ie(ie), .i_intr(intr),
    .i_decode_error_p1(decerr_p1), .i_syscall_p1(syscall_p1), .i_break_p1(break_p1),
    .i_overflow_p2(ovf_p2), .i_addr_error_p3(addrerr_p3),
    .i_valid_p1(valid_p1), .i_valid_p2(valid_p2), .i_valid_p3(valid_p3),
    .i_pc_p1(pc_p1), .i_pc_p2(pc_p2), .i_pc_p3(pc_p3),
    .i_dly_slt_p1(dly_p1), .i_dly_slt_p2(dly_p2), .i_dly_slt_p3(dly_p3),
    .o_exc(u_if)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask
  task automatic clr();
    {exec_stall, mem_stall, fetch_stall, intr, ie} = '0;
    {decerr_p1, syscall_p1, break_p1, ovf_p2, addrerr_p3} = '0;
    {valid_p1, valid_p2, valid_p3, dly_p1, dly_p2, dly_p3} = '0;
    {pc_p1, pc_p2, pc_p3} = '0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [3:0] nul();
    return {u_if.nullify_decode, u_if.nullify_execute, u_if.nullify_mem, u_if.nullify_wb};
  endfunction
  initial begin
    logic seen;
    clr();
    ivtbase = 22'h000004;
    idle(3);
    chk("rst_start", 32'(u_if.except_start), 0);
    chk("rst_null", 32'(nul()), 0);
    chk("rst_redir", 32'(u_if.redirect), 0);
    chk("rst_raddr", u_if.except_raddr, 0);
    chk("rst_vec", u_if.redirect_addr, 0);
    rst = 0;
    idle(2);
    // overflow at execute
    valid_p2 = 1; ovf_p2 = 1; pc_p2 = 32'h1040;
    @(negedge clk);
    chk("ovf_start", 32'(u_if.except_start), 1);
    chk("ovf_raddr", u_if.except_raddr, 32'h1040);
    chk("ovf_rdly", u_if.except_raddr_dly, 32'h103C);
    chk("ovf_dly", 32'(u_if.except_dly_slt), 0);
    chk("ovf_null", 32'(nul()), 32'hF);
    chk("ovf_redir", 32'(u_if.redirect), 1);
    chk("ovf_vec", u_if.redirect_addr, 32'h1060);
    clr();
    @(negedge clk);
    chk("ovf_one_cycle", 32'(u_if.except_start), 0);
    chk("ovf_drain_null", 32'(nul()), 0);
    idle(4);
    // syscall in a delay slot
    valid_p1 = 1; syscall_p1 = 1; pc_p1 = 32'h2004; dly_p1 = 1;
    @(negedge clk);
    chk("sys_start", 32'(u_if.except_start), 1);
    chk("sys_dly", 32'(u_if.except_dly_slt), 1);
    chk("sys_rdly", u_if.except_raddr_dly, 32'h2000);
    chk("sys_vec", u_if.redirect_addr, 32'h1080);
    clr();
    idle(5);
    // addr error beats break; overflow during drain is ignored
    valid_p3 = 1; addrerr_p3 = 1; pc_p3 = 32'h3000;
    valid_p1 = 1; break_p1 = 1; pc_p1 = 32'h3008;
    @(negedge clk);
    chk("prio_start", 32'(u_if.except_start), 1);
    chk("prio_raddr", u_if.except_raddr, 32'h3000);
    chk("prio_vec", u_if.redirect_addr, 32'h1040);
    clr();
    @(negedge clk);
    valid_p2 = 1; ovf_p2 = 1; pc_p2 = 32'h3100;
    @(negedge clk);
    chk("drain_ign1", 32'(u_if.except_start), 0);
    @(negedge clk);
    chk("drain_ign2", 32'(u_if.except_start), 0);
    clr();
    @(negedge clk);
    chk("drain_ign3", 32'(u_if.except_start), 0);
    idle(3);
    // invalid stage ignored
    valid_p2 = 0; ovf_p2 = 1; pc_p2 = 32'h4000;
    idle(2);
    chk("inval_start", 32'(u_if.except_start), 0);
    clr();
    idle(2);
    // interrupt masked, then enabled
    valid_p2 = 1; pc_p2 = 32'h5000; intr = 1; ie = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (u_if.except_start) seen = 1;
    end
    chk("intr_masked", 32'(seen), 0);
    ie = 1;
    seen = 0;
    for (int i = 0; i < 3 && !seen; i++) begin
      @(negedge clk);
      seen = u_if.except_start;
    end
    chk("intr_seen", 32'(seen), 1);
    chk("intr_raddr", u_if.except_raddr, 32'h5000);
    chk("intr_vec", u_if.redirect_addr, 32'h1020);
    clr();
    idle(6);
    // stall holds ENTRY
    valid_p2 = 1; ovf_p2 = 1; pc_p2 = 32'h8000;
    @(negedge clk);
    chk("stall_start0", 32'(u_if.except_start), 1);
    clr();
    exec_stall = 1;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("stall_start%0d", i), 32'(u_if.except_start), 1);
    end
    chk("stall_raddr", u_if.except_raddr, 32'h8000);
    exec_stall = 0;
    @(negedge clk);
    chk("stall_leave", 32'(u_if.except_start), 0);
    idle(5);
    // reset during drain
    valid_p2 = 1; ovf_p2 = 1; pc_p2 = 32'h6000;
    @(negedge clk);
    clr();
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_drain_start", 32'(u_if.except_start), 0);
    chk("rst_drain_null", 32'(nul()), 0);
    chk("rst_drain_vec", u_if.redirect_addr, 0);
    rst = 0;
    valid_p2 = 1; ovf_p2 = 1; pc_p2 = 32'h7000;
    @(negedge clk);
    chk("post_rst_start", 32'(u_if.except_start), 1);
    chk("post_rst_raddr", u_if.except_raddr, 32'h7000);
    clr();
    idle(5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
